// File: rtl/pdl_race_reader_if.sv
// ============================================================================
// Module      : pdl_race_reader_if
// Description : Challenge/response handshake and PDL/arbiter signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pdl_race_reader_if #(
    parameter int N_BITS = 8
);
    logic                  ch_valid;
    logic                  ch_ready;
    logic [2*N_BITS-1:0]   ch_data;
    logic [1:0]            pdl_sel;
    logic                  launch;
    logic                  arb_in;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [N_BITS-1:0]     resp_data;
    logic [N_BITS-1:0]     resp_unstable;

    // Controller side
    modport slave (
        input  ch_valid, ch_data, arb_in, resp_ready,
        output ch_ready, pdl_sel, launch, resp_valid, resp_data, resp_unstable
    );

    // Challenge source / response consumer / PDL model side
    modport master (
        output ch_valid, ch_data, arb_in, resp_ready,
        input  ch_ready, pdl_sel, launch, resp_valid, resp_data, resp_unstable
    );
endinterface

`default_nettype wire

// File: rtl/pdl_race_reader.sv
// ============================================================================
// Module      : pdl_race_reader
// Description : PDL-pair race controller; majority-votes N_VOTES races per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdl_race_reader #(
    parameter int N_BITS        = 8,
    parameter int N_VOTES       = 5,
    parameter int SETTLE_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pdl_race_reader_if.slave   bus
);

    localparam int c_BIT_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int c_VOTE_W  = $clog2(N_VOTES + 1);
    localparam int c_CNT_W   = $clog2(SETTLE_CYCLES);

    localparam logic [c_BIT_W-1:0]  c_LAST_BIT = c_BIT_W'(N_BITS - 1);
    localparam logic [c_VOTE_W-1:0] c_VOTES    = c_VOTE_W'(N_VOTES);
    localparam logic [c_VOTE_W-1:0] c_HALF     = c_VOTE_W'(N_VOTES / 2);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_LAUNCH  = 3'd2,
        S_RECOVER = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [2*N_BITS-1:0]    r_chal;
    logic [c_BIT_W-1:0]     r_bit;
    logic [c_VOTE_W-1:0]    r_votes;
    logic [c_VOTE_W-1:0]    r_ones;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [1:0]             r_pdl_sel;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [N_BITS-1:0]      r_resp_data;
    logic [N_BITS-1:0]      r_resp_unstable;

    logic                   w_last;
    logic                   w_last_bit;
    logic                   w_votes_done;
    logic [c_BIT_W-1:0]     w_bit_inc;
    logic [2*N_BITS-1:0]    w_chal_shift;
    logic                   w_ch_ready;
    logic                   w_launch;
    logic                   w_resp_valid;

    assign w_last       = (r_cnt == c_CNT_LAST);
    assign w_last_bit   = (r_bit == c_LAST_BIT);
    assign w_votes_done = (r_votes == c_VOTES);
    assign w_bit_inc    = r_bit + c_BIT_W'(1);
    assign w_chal_shift = r_chal >> {w_bit_inc, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ch_ready   = 1'b0;
        w_launch     = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ch_ready = 1'b1;
                if (bus.ch_valid) w_next = S_SETUP;
            end
            S_SETUP: begin
                if (w_last) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_launch = 1'b1;
                if (w_last) w_next = S_RECOVER;
            end
            S_RECOVER: begin
                if (w_last) begin
                    if (!w_votes_done)   w_next = S_LAUNCH;
                    else if (w_last_bit) w_next = S_DONE;
                    else                 w_next = S_SETUP;
                end
            end
            S_DONE: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Timer restarts on every state change and parks at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (!w_last) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.arb_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chal          <= '0;
            r_bit           <= '0;
            r_votes         <= '0;
            r_ones          <= '0;
            r_pdl_sel       <= 2'b00;
            r_resp_data     <= '0;
            r_resp_unstable <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ch_valid) begin
                        r_chal    <= bus.ch_data;
                        r_bit     <= '0;
                        r_votes   <= '0;
                        r_ones    <= '0;
                        r_pdl_sel <= bus.ch_data[1:0];
                    end
                end
                S_LAUNCH: begin
                    if (w_last) begin
                        r_ones  <= r_ones + c_VOTE_W'(r_sync2);
                        r_votes <= r_votes + c_VOTE_W'(1);
                    end
                end
                S_RECOVER: begin
                    if (w_last && w_votes_done) begin
                        r_resp_data[r_bit]     <= (r_ones > c_HALF);
                        r_resp_unstable[r_bit] <= (r_ones != '0) && (r_ones != c_VOTES);
                        r_ones                 <= '0;
                        r_votes                <= '0;
                        if (!w_last_bit) begin
                            r_bit     <= w_bit_inc;
                            r_pdl_sel <= w_chal_shift[1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ch_ready      = w_ch_ready;
    assign bus.launch        = w_launch;
    assign bus.resp_valid    = w_resp_valid;
    assign bus.pdl_sel       = r_pdl_sel;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_unstable = r_resp_unstable;

endmodule

`default_nettype wire

// File: tb/tb_pdl_race_reader.sv
// ============================================================================
// Module      : tb_pdl_race_reader
// Description : Directed self-checking bench for pdl_race_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdl_race_reader;

    localparam int N_BITS  = 8;
    localparam int N_VOTES = 5;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pdl_race_reader_if #(.N_BITS(N_BITS)) bus ();

    pdl_race_reader #(
        .N_BITS        (N_BITS),
        .N_VOTES       (N_VOTES),
        .SETTLE_CYCLES (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one challenge until resp_valid; arb_in follows pat, one bit per race.
    task automatic run_meas(input logic [15:0] chal, input logic [15:0] alt,
                            input logic keep_valid, input logic [39:0] pat,
                            output int lat, output int first_rise, output int pulses,
                            output int wmin, output int wmax,
                            output logic [15:0] seq, output logic sel_err);
        int   n, rises, w, b, v;
        logic prev;
        @(negedge clk);
        bus.ch_data  = chal;
        bus.ch_valid = 1'b1;
        bus.arb_in   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.ch_data  = alt;
        bus.ch_valid = keep_valid;
        n = 0; rises = 0; w = 0; prev = 1'b0;
        wmin = 1000; wmax = 0; seq = '0; sel_err = 1'b0; lat = -1; first_rise = -1;
        while (n <= 1000) begin
            if (bus.launch && !prev) begin
                b = rises / N_VOTES;
                v = rises % N_VOTES;
                if (rises == 0) first_rise = n;
                if (b < N_BITS) begin
                    if (v == 0) seq[2*b +: 2] = bus.pdl_sel;
                    else if (seq[2*b +: 2] !== bus.pdl_sel) sel_err = 1'b1;
                    bus.arb_in = pat[b*N_VOTES + v];
                end
                rises++;
                w = 0;
            end
            if (bus.launch) w++;
            if (!bus.launch && prev) begin
                if (w < wmin) wmin = w;
                if (w > wmax) wmax = w;
            end
            prev = bus.launch;
            if (bus.resp_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        bus.ch_valid = 1'b0;
        pulses = rises;
    endtask

    task automatic accept_resp();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.ch_ready !== 1'b1 || bus.launch !== 1'b0 || bus.pdl_sel !== 2'd0 ||
            bus.resp_valid !== 1'b0 || bus.resp_data !== 8'h00 || bus.resp_unstable !== 8'h00) begin
            n_err++;
            $display("FAIL reset_values got rdy=%b l=%b sel=%0d v=%b d=%h u=%h required rdy=1 l=0 sel=0 v=0 d=00 u=00",
                     bus.ch_ready, bus.launch, bus.pdl_sel, bus.resp_valid, bus.resp_data, bus.resp_unstable);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        int lat, fr, pulses, wmin, wmax;
        logic [15:0] seq;
        logic sel_err;
        run_meas(16'h1B1B, 16'h1B1B, 1'b0, {40{1'b1}}, lat, fr, pulses, wmin, wmax, seq, sel_err);
        n_vec++;
        if (lat !== 352) begin n_err++; $display("FAIL ones_latency got %0d required 352", lat); end
        n_vec++;
        if (fr !== 4) begin n_err++; $display("FAIL ones_first_launch got %0d required 4", fr); end
        n_vec++;
        if (seq !== 16'h1B1B) begin n_err++; $display("FAIL ones_sel_seq got %h required 1b1b", seq); end
        n_vec++;
        if (sel_err !== 1'b0) begin n_err++; $display("FAIL ones_sel_stable got %b required 0", sel_err); end
        n_vec++;
        if (bus.resp_data !== 8'hFF) begin n_err++; $display("FAIL ones_data got %h required ff", bus.resp_data); end
        n_vec++;
        if (bus.resp_unstable !== 8'h00) begin n_err++; $display("FAIL ones_unstable got %h required 00", bus.resp_unstable); end
        accept_resp();
    endtask

    task automatic test_all_zeros();
        int lat, fr, pulses, wmin, wmax;
        logic [15:0] seq;
        logic sel_err;
        run_meas(16'hE4E4, 16'hE4E4, 1'b0, 40'h0, lat, fr, pulses, wmin, wmax, seq, sel_err);
        n_vec++;
        if (pulses !== 40) begin n_err++; $display("FAIL zeros_pulses got %0d required 40", pulses); end
        n_vec++;
        if (wmin !== 4 || wmax !== 4) begin n_err++; $display("FAIL zeros_width got min=%0d max=%0d required 4", wmin, wmax); end
        n_vec++;
        if (seq !== 16'hE4E4) begin n_err++; $display("FAIL zeros_sel_seq got %h required e4e4", seq); end
        n_vec++;
        if (bus.resp_data !== 8'h00 || bus.resp_unstable !== 8'h00) begin
            n_err++;
            $display("FAIL zeros_resp got d=%h u=%h required d=00 u=00", bus.resp_data, bus.resp_unstable);
        end
        accept_resp();
    endtask

    task automatic test_majority();
        int lat, fr, pulses, wmin, wmax;
        logic [15:0] seq;
        logic sel_err;
        // bit 2 voted 1 on 3 of 5 races
        run_meas(16'h1234, 16'h1234, 1'b0, 40'h00_0000_5400, lat, fr, pulses, wmin, wmax, seq, sel_err);
        n_vec++;
        if (bus.resp_data !== 8'h04 || bus.resp_unstable !== 8'h04) begin
            n_err++;
            $display("FAIL maj_3of5 got d=%h u=%h required d=04 u=04", bus.resp_data, bus.resp_unstable);
        end
        accept_resp();
        // bit 2 voted 1 on 2 of 5 races
        run_meas(16'h1234, 16'h1234, 1'b0, 40'h00_0000_1400, lat, fr, pulses, wmin, wmax, seq, sel_err);
        n_vec++;
        if (bus.resp_data !== 8'h00 || bus.resp_unstable !== 8'h04) begin
            n_err++;
            $display("FAIL maj_2of5 got d=%h u=%h required d=00 u=04", bus.resp_data, bus.resp_unstable);
        end
        accept_resp();
    endtask

    task automatic test_backpressure();
        int lat, fr, pulses, wmin, wmax, bad;
        logic [15:0] seq;
        logic sel_err;
        run_meas(16'h0F0F, 16'h0F0F, 1'b0, 40'h00_0000_5400, lat, fr, pulses, wmin, wmax, seq, sel_err);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.ch_valid = i[0];
            bus.ch_data  = 16'hFFFF;
            @(negedge clk);
            n_vec++;
            if (bus.resp_valid !== 1'b1 || bus.ch_ready !== 1'b0 ||
                bus.resp_data !== 8'h04 || bus.resp_unstable !== 8'h04) begin
                n_err++;
                bad++;
                if (bad < 4)
                    $display("FAIL hold_cycle%0d got v=%b rdy=%b d=%h u=%h required v=1 rdy=0 d=04 u=04",
                             i, bus.resp_valid, bus.ch_ready, bus.resp_data, bus.resp_unstable);
            end
        end
        bus.ch_valid = 1'b1;
        accept_resp();
        n_vec++;
        if (bus.resp_valid !== 1'b0 || bus.ch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL handshake_exit got v=%b rdy=%b required v=0 rdy=1", bus.resp_valid, bus.ch_ready);
        end
        bus.ch_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, fr, pulses, wmin, wmax;
        logic [15:0] seq;
        logic sel_err;
        @(negedge clk);
        bus.ch_data  = 16'h1B1B;
        bus.ch_valid = 1'b1;
        bus.arb_in   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ch_valid = 1'b0;
        repeat (225) @(negedge clk);
        n_vec++;
        if (bus.launch !== 1'b1 || bus.pdl_sel !== 2'd2) begin
            n_err++;
            $display("FAIL pre_reset_bit5 got l=%b sel=%0d required l=1 sel=2", bus.launch, bus.pdl_sel);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.launch !== 1'b0 || bus.ch_ready !== 1'b1 || bus.pdl_sel !== 2'd0 || bus.resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got l=%b rdy=%b sel=%0d v=%b required l=0 rdy=1 sel=0 v=0",
                     bus.launch, bus.ch_ready, bus.pdl_sel, bus.resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // bit 0: 4 of 5 ones, bit 7: 1 of 5 ones
        run_meas(16'hE4E4, 16'hE4E4, 1'b0, 40'h08_0000_000F, lat, fr, pulses, wmin, wmax, seq, sel_err);
        n_vec++;
        if (lat !== 352) begin n_err++; $display("FAIL post_reset_latency got %0d required 352", lat); end
        n_vec++;
        if (bus.resp_data !== 8'h01 || bus.resp_unstable !== 8'h81) begin
            n_err++;
            $display("FAIL post_reset_resp got d=%h u=%h required d=01 u=81", bus.resp_data, bus.resp_unstable);
        end
        accept_resp();
    endtask

    task automatic test_capture();
        int lat, fr, pulses, wmin, wmax;
        logic [15:0] seq;
        logic sel_err;
        run_meas(16'h1B1B, 16'hE4E4, 1'b1, 40'h00_0000_03FF, lat, fr, pulses, wmin, wmax, seq, sel_err);
        n_vec++;
        if (seq !== 16'h1B1B) begin n_err++; $display("FAIL capture_sel_seq got %h required 1b1b", seq); end
        n_vec++;
        if (lat !== 352) begin n_err++; $display("FAIL capture_latency got %0d required 352", lat); end
        n_vec++;
        if (bus.resp_data !== 8'h03 || bus.resp_unstable !== 8'h00) begin
            n_err++;
            $display("FAIL capture_resp got d=%h u=%h required d=03 u=00", bus.resp_data, bus.resp_unstable);
        end
        accept_resp();
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        bus.ch_valid   = 1'b0;
        bus.ch_data    = '0;
        bus.arb_in     = 1'b0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_majority();
        test_backpressure();
        test_async_reset();
        test_capture();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pdl_race_reader.md
# pdl_race_reader

Measurement controller for the PUF's programmable-delay-line pair. It accepts an N_BITS challenge and applies each 2-bit slice as the delay select to both PDLs. For each bit it fires N_VOTES launch edges into the race and samples the arbiter result each time. It majority-votes the samples into one response bit and returns the response word plus a per-bit instability mask over a valid/ready handshake.

## Interface
- N_BITS, 8, response bits per challenge; challenge width is 2*N_BITS
- N_VOTES, 5, races per response bit; odd, ≥1
- SETTLE_CYCLES, 4, cycles spent in each timed state; ≥3 (covers the 2-flop synchronizer)

Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_valid  in  1  challenge offered
- ch_ready  out  1  controller idle, challenge accepted when ch_valid&&ch_ready
- ch_data  in  2*N_BITS  challenge; slice [2i+1:2i] drives bit i
- pdl_sel  out  2  delay select to both PDLs
- launch  out  1  race edge into both PDL inputs
- arb_in  in  1  arbiter latch output (asynchronous, 2-flop synchronized internally)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_data  out  N_BITS  majority-voted response, bit i from slice i
- resp_unstable  out  N_BITS  bit i set when votes for bit i were not unanimous

## Operation
- States: IDLE, SETUP, LAUNCH, RECOVER, DONE.
- IDLE: ch_ready=1, launch=0. On handshake, capture ch_data, clear bit index, vote counter and ones counter, then go to SETUP.
- SETUP: pdl_sel=slice[bit]; launch=0; lasts SETTLE_CYCLES; then go to LAUNCH.
- LAUNCH: launch=1 for SETTLE_CYCLES. In the last cycle, add the synchronized arb_in to the ones counter. Then go to RECOVER.
- RECOVER: launch=0 for SETTLE_CYCLES (arbiter re-arms). At the end, if fewer than N_VOTES votes have been taken, return to LAUNCH. Otherwise:
  - resp_data[bit] = (ones > N_VOTES/2)
  - resp_unstable[bit] = (ones != 0 && ones != N_VOTES)
  - clear the ones counter
  - if bit < N_BITS-1, increment bit and go to SETUP; else go to DONE.
- DONE: resp_valid=1; resp_data and resp_unstable are held stable. On resp_ready, go to IDLE.
- pdl_sel changes only on entry to SETUP and stays constant across all votes of a bit.
- Width rules:
  - ones counter width is $clog2(N_VOTES+1).
  - bit index width is $clog2(N_BITS) (minimum 1).
  - the cycle counter saturates at SETTLE_CYCLES-1 and is reset on each state change.
- ch_valid is ignored outside IDLE; the captured challenge is unaffected by later changes to ch_data.
- Reset (any state, including mid-LAUNCH) asynchronously forces:
  - state=IDLE, launch=0, pdl_sel=0
  - resp_valid=0, resp_data=0, resp_unstable=0
  - ch_ready=1, all counters and synchronizer flops 0
  - the partial measurement is discarded.

## Timing
- Reset values: ch_ready=1, launch=0, pdl_sel=0, resp_valid=0, resp_data=0, resp_unstable=0.
- Handshake at edge E0 → SETUP active from E0; ch_ready=0 from E0.
- Per bit: SETTLE_CYCLES*(1+2*N_VOTES) cycles. resp_valid rises at edge E0+N_BITS*SETTLE_CYCLES*(1+2*N_VOTES); with defaults, E0+352.
- The first launch rise occurs SETTLE_CYCLES cycles after E0. Each launch pulse is high for exactly SETTLE_CYCLES cycles.
- arb_in must be stable for ≥2 cycles before the last LAUNCH cycle to be counted.
- DONE handshake at edge E1 → resp_valid=0 and ch_ready=1 from E1. No challenge is accepted in the same cycle as the response handshake.
- resp_valid stays high indefinitely while resp_ready=0.

## Test plan
- arb_in held 1, ch_data=0x1B1B, resp_ready=1 → pdl_sel sequence 3,2,1,0,3,2,1,0; resp_valid at E0+352; resp_data=0xFF; resp_unstable=0x00.
- arb_in held 0 → resp_data=0x00, resp_unstable=0x00; exactly 40 launch pulses, each 4 cycles wide.
- arb_in driven 1 on 3 of 5 votes for bit 2 only, 0 elsewhere → resp_data=0x04, resp_unstable=0x04. With 2 of 5 votes instead → resp_data=0x00, resp_unstable=0x04.
- resp_ready held 0 for 20 cycles after resp_valid → resp_data, resp_unstable and resp_valid stable; ch_ready=0; ch_valid pulses ignored. ch_ready=1 the cycle after the handshake.
- rst_n asserted mid-LAUNCH of bit 5 → launch=0 and ch_ready=1 immediately (before the next clk edge); the next challenge measures cleanly with the full 352-cycle latency.
- ch_data changed during a measurement → the response reflects the challenge captured at handshake only.
